csa_nibble_sequencer: RTL
=========================

# csa_nibble_sequencer

Multi-precision add sequencer that wraps the 4-bit carry select adder (CSA). It accepts a wide operand pair over a valid/ready handshake and drives the external CSA one nibble per cycle, least-significant first. It chains the carry between nibbles, assembles the wide sum, and presents it over a second valid/ready handshake. It sits directly upstream of the CSA, which it feeds, and directly downstream of it, consuming S/Cout.

## Interface
- NIBBLES, default 4: number of 4-bit slices. Legal range 2..16. Operand width W = 4*NIBBLES.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand pair present
- in_ready  output  1  block can accept operands; high only in IDLE
- A_in  input  W  operand A
- B_in  input  W  operand B
- Cin_in  input  1  carry-in
- csa_A  output  4  nibble of A to CSA A
- csa_B  output  4  nibble of B to CSA B
- csa_Cin  output  1  carry to CSA Cin
- csa_S  input  4  CSA S, combinational response to csa_*
- csa_Cout  input  1  CSA Cout
- out_valid  output  1  Sum/Cout valid
- out_ready  input  1  consumer takes result
- Sum  output  W  A_in + B_in + Cin_in, modulo 2^W
- Cout  output  1  carry out of bit W-1
- busy  output  1  high in RUN or DONE

## Operation
- Reset is asynchronous and active-low. The block has one clock.
- All registers reset to 0: operands, carry, idx, Sum, Cout, out_valid.
- State resets to IDLE. In reset, in_ready = 1 and busy = 0.
- States are IDLE, RUN and DONE.
- **IDLE**
  - in_ready = 1. csa_A, csa_B and csa_Cin = 0.
  - On in_valid & in_ready: register A_in, B_in and Cin_in (carry_reg = Cin_in), set idx = 0, go to RUN.
- **RUN**
  - in_ready = 0.
  - csa_A = A_reg[4*idx+3 : 4*idx], csa_B likewise, csa_Cin = carry_reg. All are driven combinationally from registers only.
  - Each edge: Sum[4*idx+3 : 4*idx] <= csa_S, carry_reg <= csa_Cout, idx <= idx+1.
  - On the edge where idx == NIBBLES-1: Cout <= csa_Cout, out_valid <= 1, go to DONE.
- **DONE**
  - out_valid = 1. Sum and Cout are held stable. csa_* = 0. in_valid is ignored.
  - On out_valid & out_ready: out_valid <= 0, go to IDLE.
- Sum and Cout keep their last value after DONE until overwritten by the next operation. They are valid only while out_valid = 1.
- idx width is clog2(NIBBLES). idx never exceeds NIBBLES-1.
- Reset mid-operation (RUN or DONE) aborts the operation. All state returns to reset values immediately, and no partial result is presented.

## Timing
- Accept edge E0 (in_valid & in_ready sampled high).
- Nibble k is presented to the CSA during the cycle after edge E(k) and captured at E(k+1).
- out_valid rises after edge E(NIBBLES). Latency from accept to out_valid is NIBBLES cycles.
- The CSA path is combinational: csa_* (from regs) -> CSA -> csa_S/csa_Cout -> capture registers. It must close in one cycle.
- The output handshake completes on the first edge with out_valid & out_ready. in_ready rises after that edge.
- Minimum spacing between accepts is NIBBLES+2 cycles (6 for NIBBLES = 4) with out_ready held high.
- in_valid held high during RUN or DONE is not accepted. The operand is taken on the first IDLE edge.

## Test plan
Bench instantiates the CSA between csa_* and csa_S/csa_Cout, with NIBBLES = 4 unless stated.
- Reset: hold rst_n = 0 with random inputs -> in_ready = 1, out_valid = 0, Sum = 0x0000, Cout = 0, busy = 0, csa_* = 0.
- A_in = 0x1234, B_in = 0x4321, Cin_in = 0, out_ready = 1 -> csa_A sequence 4, 3, 2, 1. out_valid exactly 4 cycles after accept, with Sum = 0x5555 and Cout = 0.
- A_in = 0xFFFF, B_in = 0x0000, Cin_in = 1 -> csa_Cin sequence 1, 1, 1, 1, then Sum = 0x0000 and Cout = 1.
- Backpressure: A_in = 0x8000, B_in = 0x8000, Cin_in = 0, out_ready = 0 for 5 cycles after out_valid, in_valid held high with A_in = 0x0001 -> Sum = 0x0000 and Cout = 1 stable, in_ready = 0. After out_ready = 1: one IDLE cycle, then the next op is accepted.
- Reset mid-RUN: assert rst_n = 0 after 2 nibbles of A_in = 0xABCD, B_in = 0x1111 -> all outputs at reset values asynchronously. The next op 0x0F0F + 0x00F1 + 0 gives Sum = 0x1000 and Cout = 0.
- Random: 500 ops with NIBBLES = 4 and 100 ops with NIBBLES = 8, random out_ready and in_valid gaps -> every {Cout, Sum} equals A_in + B_in + Cin_in, and no op is lost or duplicated.

Source files
------------

// File: rtl/csa_nibble_sequencer.sv
// Multi-precision add sequencer: feeds an external 4-bit carry select adder one
// nibble per cycle (LSB first), chains the carry and returns the wide sum.
module csa_nibble_sequencer #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   A_in,
  input  logic [4*NIBBLES-1:0]   B_in,
  input  logic                   Cin_in,
  output logic [3:0]             csa_A,
  output logic [3:0]             csa_B,
  output logic                   csa_Cin,
  input  logic [3:0]             csa_S,
  input  logic                   csa_Cout,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   Sum,
  output logic                   Cout,
  output logic                   busy
);

  localparam int unsigned W     = 4 * NIBBLES;
  localparam int unsigned IDX_W = $clog2(NIBBLES);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q;
  logic [W-1:0]       a_q;
  logic [W-1:0]       b_q;
  logic               carry_q;
  logic [IDX_W-1:0]   idx_q;
  logic [W-1:0]       sum_q;
  logic               cout_q;
  logic               out_valid_q;

  // CSA operands come straight from registers so the adder path closes in one cycle
  always_comb begin
    csa_A   = 4'h0;
    csa_B   = 4'h0;
    csa_Cin = 1'b0;
    if (state_q == RUN) begin
      csa_A   = a_q[{idx_q, 2'b00} +: 4];
      csa_B   = b_q[{idx_q, 2'b00} +: 4];
      csa_Cin = carry_q;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign Sum       = sum_q;
  assign Cout      = cout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= A_in;
            b_q     <= B_in;
            carry_q <= Cin_in;
            idx_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q[{idx_q, 2'b00} +: 4] <= csa_S;
          carry_q                    <= csa_Cout;
          // Last nibble: latch final carry and wrap idx so it never passes NIBBLES-1
          if (idx_q == IDX_W'(NIBBLES - 1)) begin
            idx_q       <= '0;
            cout_q      <= csa_Cout;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
